// File: rtl/alu_fpga_harness.sv
// rtl/alu_fpga_harness.sv - board-level operand/result harness for exercising an external ALU
//
// Purpose:
//   Builds DATA_W-bit A/B operands from 16-bit switch chunks and issues an
//   opcode on a debounced key press. It then waits ALU_LAT cycles, latches the
//   ALU result and flags, and shows the result on a pageable 7-segment display.
//
// Ports:
//   CLOCK_50, nRST          clock, asynchronous active-low reset
//   key_n[3:0]              raw active-low keys: 0 load, 1 exec, 2 page, 3 clear
//   sw_data, sw_target,     chunk value, target operand (0 A / 1 B),
//   sw_chunk, sw_op         chunk index, opcode sampled on exec
//   alu_a, alu_b, alu_op    registered operands and opcode to the ALU
//   alu_out, alu_neg,       ALU result and flags
//   alu_over, alu_zero
//   hex_seg                 active-low segments, digit i at [7i+6:7i], {g,f,e,d,c,b,a}
//   flags                   latched {neg, over, zero}
//   busy                    high while waiting for the ALU result
//   page                    current display page
//
// Optional feature macro: ALU_HARNESS_SEXT_EN
//   When defined, a load to chunk 0 also sign-fills all operand bits above bit 15.

module alu_fpga_harness #(
    parameter int DATA_W       = 32,
    parameter int SEG_DIGITS   = 8,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int ALU_LAT      = 1,
    localparam int NCHUNK = DATA_W / 16,
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
    localparam int NPAGES = (DATA_W + 4 * SEG_DIGITS - 1) / (4 * SEG_DIGITS),
    localparam int PW     = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
    input  logic                    CLOCK_50,
    input  logic                    nRST,
    input  logic [3:0]              key_n,
    input  logic [15:0]             sw_data,
    input  logic                    sw_target,
    input  logic [CW-1:0]           sw_chunk,
    input  logic [3:0]              sw_op,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [3:0]              alu_op,
    input  logic [DATA_W-1:0]       alu_out,
    input  logic                    alu_neg,
    input  logic                    alu_over,
    input  logic                    alu_zero,
    output logic [7*SEG_DIGITS-1:0] hex_seg,
    output logic [2:0]              flags,
    output logic                    busy,
    output logic [PW-1:0]           page
);

    localparam int NNIB = DATA_W / 4;
    localparam int DBW  = $clog2(DEBOUNCE_CYC);
    localparam int LW   = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Key front end: 2-FF synchroniser, per-key stability counter.
    // stable_q holds the accepted (active-low) level; 1 means released.
    // ------------------------------------------------------------------
    logic [3:0]     sync1_q;
    logic [3:0]     sync2_q;
    logic [3:0]     stable_q;
    logic [3:0]     pulse_q;
    logic [DBW-1:0] db_cnt_q [4];

    always_ff @(posedge CLOCK_50 or negedge nRST) begin
        if (!nRST) begin
            sync1_q  <= 4'hF;
            sync2_q  <= 4'hF;
            stable_q <= 4'hF;
            pulse_q  <= 4'h0;
            for (int k = 0; k < 4; k++) begin
                db_cnt_q[k] <= '0;
            end
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            for (int k = 0; k < 4; k++) begin
                pulse_q[k] <= 1'b0;
                if (sync2_q[k] == stable_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DBW'(DEBOUNCE_CYC - 1)) begin
                    // DEBOUNCE_CYC-th consecutive cycle at the new level
                    stable_q[k] <= sync2_q[k];
                    db_cnt_q[k] <= '0;
                    pulse_q[k]  <= ~sync2_q[k];
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Priority: clear > exec > load > page; losers in the same cycle are dropped.
    logic clr_p, exec_p, load_p, page_p;
    assign clr_p  = pulse_q[3];
    assign exec_p = pulse_q[1] & ~pulse_q[3];
    assign load_p = pulse_q[0] & ~pulse_q[1] & ~pulse_q[3];
    assign page_p = pulse_q[2] & ~pulse_q[0] & ~pulse_q[1] & ~pulse_q[3];

    // ------------------------------------------------------------------
    // Registers and load datapath
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic [3:0]        op_q;
    logic [2:0]        flags_q;
    logic              busy_q;
    logic [PW-1:0]     page_q;
    logic [LW-1:0]     wait_q;

    logic [DATA_W-1:0] ld_val_d;
    logic              ld_ok_d;
    logic [PW-1:0]     page_d;

    always_comb begin
        ld_val_d = sw_target ? b_q : a_q;
`ifdef ALU_HARNESS_SEXT_EN
        if (sw_chunk == '0) begin
            for (int bi = 16; bi < DATA_W; bi++) begin
                ld_val_d[bi] = sw_data[15];
            end
        end
`endif
        for (int c = 0; c < NCHUNK; c++) begin
            if (sw_chunk == CW'(c)) begin
                ld_val_d[16*c +: 16] = sw_data;
            end
        end
        // Chunk indices past the operand width are ignored entirely
        ld_ok_d = ({{(32-CW){1'b0}}, sw_chunk} < 32'(NCHUNK));
    end

    always_comb begin
        page_d = '0;
        if (NPAGES > 1 && page_q != PW'(NPAGES - 1)) begin
            page_d = page_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            page_q  <= '0;
            wait_q  <= '0;
        end else if (clr_p) begin
            // Clear wins in every state and aborts an in-flight exec
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            page_q  <= '0;
            wait_q  <= '0;
        end else begin
            if (page_p) begin
                page_q <= page_d;
            end
            case (state_q)
                S_EXEC: begin
                    // Operands/opcode are frozen here; load and exec are ignored
                    if (wait_q == LW'(1)) begin
                        res_q   <= alu_out;
                        flags_q <= {alu_neg, alu_over, alu_zero};
                        busy_q  <= 1'b0;
                        wait_q  <= '0;
                        state_q <= S_HOLD;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                S_IDLE, S_HOLD: begin
                    if (exec_p) begin
                        op_q    <= sw_op;
                        busy_q  <= 1'b1;
                        wait_q  <= LW'(ALU_LAT);
                        state_q <= S_EXEC;
                    end else if (load_p && ld_ok_d) begin
                        if (sw_target) begin
                            b_q <= ld_val_d;
                        end else begin
                            a_q <= ld_val_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_enc(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b0100111;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [7*SEG_DIGITS-1:0] hex_d;
    logic [7*SEG_DIGITS-1:0] hex_q;

    always_comb begin
        hex_d = '1;
        for (int i = 0; i < SEG_DIGITS; i++) begin
            int nib;
            nib = int'(page_q) * SEG_DIGITS + i;
            if (nib < NNIB) begin
                hex_d[7*i +: 7] = seg_enc(res_q[4*nib +: 4]);
            end else begin
                hex_d[7*i +: 7] = 7'h7F;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge nRST) begin
        if (!nRST) begin
            hex_q <= {SEG_DIGITS{7'b1000000}};
        end else begin
            hex_q <= hex_d;
        end
    end

    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_op  = op_q;
    assign flags   = flags_q;
    assign busy    = busy_q;
    assign page    = page_q;
    assign hex_seg = hex_q;

endmodule

// File: doc/alu_fpga_harness.md
Name: alu_fpga_harness

Overview:
- Parametrised board-level operand/result harness for exercising the ALU on the FPGA board.
- Captures multi-chunk operands from 16 switches into registered A/B operands, and issues an opcode on a debounced key press.
- Waits a programmable ALU latency, then latches the result and flags.
- Drives a pageable 7-segment display. The ALU is instantiated outside this block and connected through the alu_* ports.

Parameters:
- DATA_W, 32, operand/result width; multiple of 16, range 16..128.
- SEG_DIGITS, 8, number of 7-segment digits driven.
- DEBOUNCE_CYC, 500000, consecutive stable cycles before a key level is accepted; minimum 2.
- ALU_LAT, 1, cycles from opcode issue to result capture; minimum 1.

Ports:
- CLOCK_50  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- key_n  in  4  raw active-low pushbuttons, asynchronous to the clock. Bit 0 = load, 1 = exec, 2 = page, 3 = clear.
- sw_data  in  16  chunk value to load.
- sw_target  in  1  load target: 0 = A, 1 = B.
- sw_chunk  in  CW  chunk index, where CW = max(1, $clog2(DATA_W/16)).
- sw_op  in  4  opcode sampled on exec.
- alu_a  out  DATA_W  registered operand A.
- alu_b  out  DATA_W  registered operand B.
- alu_op  out  4  registered opcode.
- alu_out  in  DATA_W  ALU result.
- alu_neg, alu_over, alu_zero  in  1 each  ALU flags.
- hex_seg  out  7*SEG_DIGITS  active-low segments. Digit i is at [7i+6:7i]; segment order is {g,f,e,d,c,b,a}.
- flags  out  3  latched {neg, over, zero}.
- busy  out  1  high while waiting for the ALU result.
- page  out  PW  current display page, where PW = max(1, $clog2(NPAGES)) and NPAGES = ceil(DATA_W / (4*SEG_DIGITS)).

Behaviour:
- Reset (async assert, sync release):
  - alu_a, alu_b, alu_op, result, flags, page and busy are all 0.
  - State is IDLE. Debouncers read "released".
  - Every digit displays "0" (7'b1000000).
- Key front end:
  - Each key passes through a 2-FF synchroniser, then a per-key counter.
  - The accepted level changes only after DEBOUNCE_CYC consecutive cycles at the new level.
  - A release-to-pressed change of the accepted level produces a 1-cycle pulse.
  - Bounce shorter than DEBOUNCE_CYC produces no pulse.
- Pulse priority when pulses occur in the same cycle: clear > exec > load > page. Lower-priority pulses in that cycle are dropped.
- clear, accepted in any state:
  - alu_a, alu_b, result and flags go to 0. page goes to 0.
  - An in-flight EXEC is aborted: state returns to IDLE and busy goes to 0 the next cycle.
- load, accepted in IDLE/HOLD; ignored in EXEC:
  - Writes sw_data into bits [16*sw_chunk+15 : 16*sw_chunk] of the target operand. Other bits are unchanged.
  - If sw_chunk >= DATA_W/16, the load is ignored.
- exec, accepted in IDLE/HOLD; ignored in EXEC:
  - alu_op <= sw_op; busy <= 1; wait counter <= ALU_LAT; state -> EXEC.
- FSM (IDLE, EXEC, HOLD):
  - EXEC decrements the wait counter each cycle.
  - When the counter reaches 0, on that same cycle: result <= alu_out, flags <= {alu_neg, alu_over, alu_zero}, busy <= 0, state -> HOLD.
  - A result appears ALU_LAT+1 cycles after the exec pulse.
  - HOLD behaves as IDLE for key acceptance.
- Display:
  - Digit i shows nibble n = page*SEG_DIGITS + i of the result.
  - If n >= DATA_W/4, the digit is blank (7'h7F).
  - Hex encoding, 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 0100111, 0100001, 0000110, 0001110.
  - hex_seg is registered: it reflects a result/page change 1 cycle later.
- page pulse: page increments, wrapping from NPAGES-1 to 0. With NPAGES = 1, page stays 0.
- alu_a, alu_b and alu_op are held stable throughout EXEC.

Optional Feature:
- Macro: ALU_HARNESS_SEXT_EN.
- Defined: a load to chunk 0 also fills all operand bits above bit 15 with sw_data[15], overwriting any previously loaded upper chunks. Loads to other chunks are unaffected.
- Undefined: chunk 0 loads touch only bits [15:0].

Test Plan:
- Use DEBOUNCE_CYC=4, ALU_LAT=2 and a stub ALU computing a+b with zero flag.
- Bounce and debounce:
  - Stimulus: key_n[0] low for 3 cycles, then high; then low for 6 cycles with sw_chunk=0, sw_data=16'h1234.
  - Required: no load from the 3-cycle press; exactly one load from the 6-cycle press; alu_a = 32'h0000_1234.
- Two-chunk load and exec:
  - Stimulus: load A chunk 1 with 16'hFFFF; load B chunk 0 with 16'h0001; exec with sw_op=4'h3.
  - Required: alu_op=3 one cycle after the pulse; busy high for 2 cycles; result 32'hFFFF_0001 at pulse+3; flags 3'b000; hex_seg shows "FFFF0001" one cycle after capture.
- Ignored keys during EXEC:
  - Stimulus: exec, then a load pulse while busy.
  - Required: alu_a unchanged; the captured result uses the old operands.
- Clear mid-EXEC:
  - Stimulus: clear pulse one cycle after exec.
  - Required: busy=0, state IDLE, result 0, all digits "0", and no later capture.
- Paging (DATA_W=64, SEG_DIGITS=8):
  - Stimulus: result 64'h0123_4567_89AB_CDEF, then two page pulses.
  - Required: page 0 shows "89ABCDEF"; page 1 shows "01234567"; the second pulse wraps to page 0.
- Sign extension (ALU_HARNESS_SEXT_EN defined):
  - Stimulus: load A chunk 0 with 16'h8000.
  - Required: alu_a = 32'hFFFF_8000. With the macro undefined: 32'h0000_8000.
